// File: rtl/uart_receiver_if.sv
// Receive-side signal bundle for uart_receiver: baud strobe, serial line,
// consumer handshake and status flags.
interface uart_receiver_if;
    logic       rx_clk_en;
    logic       uart_rx;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport master (
        input  rx_clk_en,
        input  uart_rx,
        input  rx_ack,
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        output busy
    );

    modport slave (
        output rx_clk_en,
        output uart_rx,
        output rx_ack,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        input  busy
    );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronises the line, samples bit centres on an
// oversampled tick and hands bytes out through a valid/ack holding register.
module uart_receiver #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic            sys_clk,
    input  logic            rst,
    uart_receiver_if.master rx
);
    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        RECOVER
    } state_e;

    state_e        state_q, state_d;
    logic          rx_meta_q, rx_s_q;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          busy_q;
    logic          deliver;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        deliver = 1'b0;
        ferr_d  = 1'b0;

        if (rx.rx_clk_en) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    if (tick_q == HALF_LAST) begin
                        if (!rx_s_q) begin
                            state_d = DATA;
                            tick_d  = '0;
                            bit_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_q == FULL_LAST) begin
                        shreg_d = {rx_s_q, shreg_q[7:1]};
                        tick_d  = '0;
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == 3'd7) begin
                            state_d = STOP;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_q == FULL_LAST) begin
                        tick_d = '0;
                        if (rx_s_q) begin
                            deliver = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = RECOVER;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                RECOVER: begin
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = RECOVER;
            endcase
        end

        // An ack in the delivery cycle frees the slot so the new byte lands.
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (rx.rx_ack && valid_q) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
        if (deliver) begin
            if (!valid_q || rx.rx_ack) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= RECOVER;
            tick_q    <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx.uart_rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            busy_q    <= (state_d != IDLE);
        end
    end

    assign rx.rx_data   = data_q;
    assign rx.rx_valid  = valid_q;
    assign rx.frame_err = ferr_q;
    assign rx.overrun   = ovr_q;
    assign rx.busy      = busy_q;
endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: OVERSAMPLE=16, baud tick every 4th
// cycle, so one bit lasts 64 sys_clk cycles.
module tb_uart_receiver;
    localparam int BIT_CYC = 64;
    // Start driven 2 cycles ahead of a tick edge K: first tick seeing rx_s=0
    // is K+4, then 8 + 8*16 + 16 ticks of 4 cycles to the stop sample.
    localparam int STOP_EDGE = 4 + (8 + 8 * 16 + 16) * 4;

    logic sys_clk = 1'b0;
    logic rst;
    logic started;
    int   n_checks = 0;
    int   n_fail = 0;
    int   fe_cnt = 0;
    int   ph = 0;
    logic [7:0] exp_q[$];

    uart_receiver_if u_if ();

    uart_receiver #(.OVERSAMPLE(16)) dut (
        .sys_clk(sys_clk),
        .rst    (rst),
        .rx     (u_if.master)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        ph = (ph + 1) % 4;
        u_if.rx_clk_en = (ph == 0);
    end

    always @(negedge sys_clk) begin
        if (u_if.frame_err === 1'b1) fe_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #2;
    endtask

    function automatic logic [7:0] pop_exp();
        if (exp_q.size() == 0) return 8'hxx;
        return exp_q.pop_front();
    endfunction

    task automatic sync_tick();
        int guard = 0;
        while (u_if.rx_clk_en !== 1'b1 && guard < 8) begin
            cyc(1);
            guard++;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        sync_tick();
        started = 1'b1;
        u_if.uart_rx = 1'b0;
        cyc(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            u_if.uart_rx = b[i];
            cyc(BIT_CYC);
        end
        u_if.uart_rx = stop_v;
        cyc(BIT_CYC);
    endtask

    task automatic pulse_ack();
        u_if.rx_ack = 1'b1;
        cyc(1);
        u_if.rx_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        u_if.uart_rx = 1'b1;
        u_if.rx_ack = 1'b0;
        started = 1'b0;
        cyc(5);
        n_checks++; if (u_if.rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", u_if.rx_data); end
        n_checks++; if (u_if.rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", u_if.rx_valid); end
        n_checks++; if (u_if.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", u_if.frame_err); end
        n_checks++; if (u_if.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", u_if.overrun); end
        n_checks++; if (u_if.busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", u_if.busy); end
        rst = 1'b0;
        cyc(12);
        n_checks++; if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", u_if.busy); end
    endtask

    task automatic test_single_byte();
        int fe0 = fe_cnt;
        logic [7:0] e;
        exp_q.push_back(8'h55);
        started = 1'b0;
        fork
            send_frame(8'h55, 1'b1);
            begin
                wait (started === 1'b1);
                cyc(STOP_EDGE - 1);
                n_checks++; if (u_if.rx_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b want 0", u_if.rx_valid); end
                cyc(1);
                e = pop_exp();
                n_checks++; if (u_if.rx_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", u_if.rx_valid); end
                n_checks++; if (u_if.rx_data !== e) begin n_fail++; $display("FAIL single_data: got %h want %h", u_if.rx_data, e); end
            end
        join
        n_checks++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL single_frame_err: got %0d pulses want 0", fe_cnt - fe0); end
        pulse_ack();
        n_checks++; if (u_if.rx_valid !== 1'b0) begin n_fail++; $display("FAIL single_ack_valid: got %b want 0", u_if.rx_valid); end
    endtask

    task automatic test_glitch();
        int fe0 = fe_cnt;
        bit seen_busy = 1'b0;
        cyc(1);
        sync_tick();
        u_if.uart_rx = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (i == 16) u_if.uart_rx = 1'b1;
            cyc(1);
            if (u_if.busy === 1'b1) seen_busy = 1'b1;
        end
        n_checks++; if (seen_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_rise: got %b want 1", seen_busy); end
        n_checks++; if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_fall: got %b want 0", u_if.busy); end
        n_checks++; if (u_if.rx_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_valid: got %b want 0", u_if.rx_valid); end
        n_checks++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL glitch_frame_err: got %0d pulses want 0", fe_cnt - fe0); end
    endtask

    task automatic test_framing();
        int fe0 = fe_cnt;
        logic [7:0] e;
        send_frame(8'hA3, 1'b0);
        cyc(30 * BIT_CYC);
        n_checks++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL break_frame_err: got %0d pulses want 1", fe_cnt - fe0); end
        n_checks++; if (u_if.rx_valid !== 1'b0) begin n_fail++; $display("FAIL break_valid: got %b want 0", u_if.rx_valid); end
        n_checks++; if (u_if.busy !== 1'b1) begin n_fail++; $display("FAIL break_busy: got %b want 1", u_if.busy); end
        u_if.uart_rx = 1'b1;
        cyc(BIT_CYC);
        n_checks++; if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL recover_busy: got %b want 0", u_if.busy); end
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        e = pop_exp();
        n_checks++; if (u_if.rx_valid !== 1'b1) begin n_fail++; $display("FAIL recover_valid: got %b want 1", u_if.rx_valid); end
        n_checks++; if (u_if.rx_data !== e) begin n_fail++; $display("FAIL recover_data: got %h want %h", u_if.rx_data, e); end
        n_checks++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL recover_frame_err: got %0d pulses want 1", fe_cnt - fe0); end
        pulse_ack();
    endtask

    task automatic test_overrun();
        logic [7:0] e;
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        e = pop_exp();
        n_checks++; if (u_if.rx_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b want 1", u_if.rx_valid); end
        n_checks++; if (u_if.rx_data !== e) begin n_fail++; $display("FAIL ovr_data: got %h want %h", u_if.rx_data, e); end
        n_checks++; if (u_if.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b want 1", u_if.overrun); end
        pulse_ack();
        n_checks++; if (u_if.rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_ack_valid: got %b want 0", u_if.rx_valid); end
        n_checks++; if (u_if.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_ack_flag: got %b want 0", u_if.overrun); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b = 8'h99;
        logic [7:0] e;
        int fe0;
        send_frame(8'h5A, 1'b1);
        send_frame(8'h66, 1'b1);
        n_checks++; if (u_if.overrun !== 1'b1) begin n_fail++; $display("FAIL pre_rst_overrun: got %b want 1", u_if.overrun); end
        sync_tick();
        u_if.uart_rx = 1'b0;
        cyc(BIT_CYC);
        for (int i = 0; i < 4; i++) begin
            u_if.uart_rx = b[i];
            cyc(BIT_CYC);
        end
        u_if.uart_rx = b[4];
        cyc(BIT_CYC / 2);
        rst = 1'b1;
        cyc(2);
        n_checks++; if (u_if.rx_data !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h want 00", u_if.rx_data); end
        n_checks++; if (u_if.rx_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", u_if.rx_valid); end
        n_checks++; if (u_if.overrun !== 1'b0) begin n_fail++; $display("FAIL midrst_overrun: got %b want 0", u_if.overrun); end
        n_checks++; if (u_if.frame_err !== 1'b0) begin n_fail++; $display("FAIL midrst_frame_err: got %b want 0", u_if.frame_err); end
        n_checks++; if (u_if.busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy: got %b want 1", u_if.busy); end
        u_if.uart_rx = 1'b1;
        rst = 1'b0;
        fe0 = fe_cnt;
        cyc(2 * BIT_CYC);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1);
        e = pop_exp();
        n_checks++; if (u_if.rx_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_rx_valid: got %b want 1", u_if.rx_valid); end
        n_checks++; if (u_if.rx_data !== e) begin n_fail++; $display("FAIL midrst_rx_data: got %h want %h", u_if.rx_data, e); end
        n_checks++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL midrst_rx_frame_err: got %0d pulses want 0", fe_cnt - fe0); end
        pulse_ack();
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        exp_q.push_back(8'h00);
        send_frame(8'h00, 1'b1);
        e = pop_exp();
        n_checks++; if (u_if.rx_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first_valid: got %b want 1", u_if.rx_valid); end
        n_checks++; if (u_if.rx_data !== e) begin n_fail++; $display("FAIL b2b_first_data: got %h want %h", u_if.rx_data, e); end
        exp_q.push_back(8'hFF);
        started = 1'b0;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                wait (started === 1'b1);
                cyc(STOP_EDGE - 1);
                u_if.rx_ack = 1'b1;
                cyc(1);
                u_if.rx_ack = 1'b0;
                e = pop_exp();
                n_checks++; if (u_if.rx_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", u_if.rx_valid); end
                n_checks++; if (u_if.rx_data !== e) begin n_fail++; $display("FAIL b2b_data: got %h want %h", u_if.rx_data, e); end
                n_checks++; if (u_if.overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %b want 0", u_if.overrun); end
            end
        join
        pulse_ack();
        n_checks++; if (u_if.rx_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_final_valid: got %b want 0", u_if.rx_valid); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_framing();
        test_overrun();
        test_reset_midframe();
        test_back_to_back();
        n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_empty: got %0d left want 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
